// File: rtl/elgamal_pkg.sv
// Shared types and constants for the ElGamal modular-exponentiation datapath.
package elgamal_pkg;

    localparam int SIZE_DEFAULT = 64;
    localparam logic [SIZE_DEFAULT-1:0] ONE = {{(SIZE_DEFAULT-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        MUL_REQ,
        MUL_WAIT,
        SQR_REQ,
        SQR_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/stream_req_channel.sv
// One valid/ready request channel: a load strobe captures data and raises valid,
// valid holds until the handshake, and a done flag records completion.
module stream_req_channel #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_tready,
    output logic [W-1:0] o_tdata,
    output logic         o_tvalid,
    output logic         o_done
);

    logic [W-1:0] r_tdata;
    logic         r_tvalid;
    logic         r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_load) begin
            r_tdata  <= i_load_data;
            r_tvalid <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_tvalid && i_tready) begin
            r_tvalid <= 1'b0;
            r_done   <= 1'b1;
        end
    end

    assign o_tdata  = r_tdata;
    assign o_tvalid = r_tvalid;
    assign o_done   = r_done;

endmodule

// File: rtl/modexp_sequencer.sv
// Square-and-multiply sequencer driving an external modular multiplier stream.
// Define MODEXP_EARLY_EXIT_EN to skip multiplies on zero exponent bits and stop once e==0.
module modexp_sequencer
    import elgamal_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   in_base_tdata,
    input  logic [SIZE-1:0]   in_exponent_tdata,
    input  logic [SIZE-1:0]   in_modulus_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [SIZE-1:0]   mul_multiplier_tdata,
    output logic              mul_multiplier_tvalid,
    input  logic              mul_multiplier_tready,
    output logic [SIZE-1:0]   mul_multiplicand_tdata,
    output logic              mul_multiplicand_tvalid,
    input  logic              mul_multiplicand_tready,
    output logic [2*SIZE-1:0] mul_modulus_tdata,
    output logic              mul_modulus_tvalid,
    input  logic              mul_modulus_tready,
    input  logic [2*SIZE-1:0] mul_product_tdata,
    input  logic              mul_product_tvalid,
    output logic              mul_product_tready,
    output logic [SIZE-1:0]   out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready
);

    localparam int IW = $clog2(SIZE + 1);
    localparam logic [SIZE-1:0] R_ONE = SIZE'(ONE);

    state_t          r_state, w_state_nxt;
    logic [SIZE-1:0] r_b, r_e, r_m, r_r;
    logic [SIZE-1:0] w_b_nxt, w_e_nxt, w_m_nxt, w_r_nxt;
    logic [IW-1:0]   r_i, w_i_nxt;

    logic            w_load, w_all_done;
    logic            w_mpl_done, w_mcd_done, w_mod_done;
    logic [SIZE-1:0] w_mpl_data, w_prod_lo;
    logic            w_unused_prod_hi;

    assign w_prod_lo        = mul_product_tdata[SIZE-1:0];
    assign w_unused_prod_hi = ^mul_product_tdata[2*SIZE-1:SIZE];
    assign w_all_done       = w_mpl_done & w_mcd_done & w_mod_done;

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_e_nxt     = r_e;
        w_m_nxt     = r_m;
        w_r_nxt     = r_r;
        w_i_nxt     = r_i;
        case (r_state)
            IDLE: begin
                if (in_tvalid) begin
                    w_b_nxt = in_base_tdata;
                    w_e_nxt = in_exponent_tdata;
                    w_m_nxt = in_modulus_tdata;
                    w_r_nxt = R_ONE;
                    w_i_nxt = '0;
                    if (in_modulus_tdata <= R_ONE) begin
                        w_r_nxt     = '0;
                        w_state_nxt = DONE;
                    end else begin
`ifdef MODEXP_EARLY_EXIT_EN
                        w_state_nxt = in_exponent_tdata[0] ? MUL_REQ : SQR_REQ;
`else
                        w_state_nxt = MUL_REQ;
`endif
                    end
                end
            end
            MUL_REQ: if (w_all_done) w_state_nxt = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_product_tvalid) begin
                    // Constant-time path: the product is always requested, only kept on a set bit
                    if (r_e[0]) w_r_nxt = w_prod_lo;
                    w_state_nxt = SQR_REQ;
                end
            end
            SQR_REQ: if (w_all_done) w_state_nxt = SQR_WAIT;
            SQR_WAIT: begin
                if (mul_product_tvalid) begin
                    w_b_nxt = w_prod_lo;
                    w_e_nxt = r_e >> 1;
                    w_i_nxt = r_i + 1'b1;
                    if (w_i_nxt == IW'(SIZE))
                        w_state_nxt = DONE;
`ifdef MODEXP_EARLY_EXIT_EN
                    else if (w_e_nxt == '0)
                        w_state_nxt = DONE;
                    else if (!w_e_nxt[0])
                        w_state_nxt = SQR_REQ;
`endif
                    else
                        w_state_nxt = MUL_REQ;
                end
            end
            DONE: if (out_tready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Requests are loaded on entry to a REQ state so all three valids rise together
    assign w_load = ((w_state_nxt == MUL_REQ) || (w_state_nxt == SQR_REQ)) &&
                    (w_state_nxt != r_state);
    assign w_mpl_data = (w_state_nxt == SQR_REQ) ? w_b_nxt : w_r_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_b     <= '0;
            r_e     <= '0;
            r_m     <= '0;
            r_r     <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_b     <= w_b_nxt;
            r_e     <= w_e_nxt;
            r_m     <= w_m_nxt;
            r_r     <= w_r_nxt;
            r_i     <= w_i_nxt;
        end
    end

    stream_req_channel #(.W(SIZE)) u_mpl (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_data(w_mpl_data),
        .i_tready(mul_multiplier_tready), .o_tdata(mul_multiplier_tdata),
        .o_tvalid(mul_multiplier_tvalid), .o_done(w_mpl_done)
    );

    stream_req_channel #(.W(SIZE)) u_mcd (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_data(w_b_nxt),
        .i_tready(mul_multiplicand_tready), .o_tdata(mul_multiplicand_tdata),
        .o_tvalid(mul_multiplicand_tvalid), .o_done(w_mcd_done)
    );

    stream_req_channel #(.W(2*SIZE)) u_mod (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_data({{SIZE{1'b0}}, w_m_nxt}),
        .i_tready(mul_modulus_tready), .o_tdata(mul_modulus_tdata),
        .o_tvalid(mul_modulus_tvalid), .o_done(w_mod_done)
    );

    assign in_tready          = (r_state == IDLE);
    assign mul_product_tready = (r_state == MUL_WAIT) || (r_state == SQR_WAIT);
    assign out_tvalid         = (r_state == DONE);
    assign out_tdata          = r_r;

endmodule
